alu_forward_stage: RTL and testbench
====================================

# alu_forward_stage

Execute-stage datapath core of the five-stage pipelined processor. It takes decoded ID/EX operands, resolves data hazards by forwarding from the EX/MEM and MEM/WB stages, computes the ALU result, and registers the EX/MEM pipeline outputs. It sits between the register-read (decode) stage and the memory-access stage.

## Interface
Parameters:
- None. Data width is fixed at 32 bits; register index width is fixed at 5 bits.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock; all state updates on the falling edge
- reset  in  1  asynchronous, active-high; clears all outputs
- writeBackControlIn  in  2  WB controls; bit 1 = RegWrite
- memAccessControlIn  in  2  MEM controls, passed through
- calculationControl  in  4  [3] regDst, [2:1] aluOp, [0] aluSrc
- readData1  in  32  register rs value
- readData2  in  32  register rt value
- immediateOperand  in  32  sign-extended immediate; [5:0] funct, [10:6] shamt
- rs, rt, rdIn  in  5 each  register indices
- memWbRegWrite  in  1  MEM/WB RegWrite
- memWbRd  in  5  MEM/WB destination
- memWbData  in  32  MEM/WB write-back data
- writeBackControlOut  out  2  registered WB controls
- memAccessControlOut  out  2  registered MEM controls
- result  out  32  registered ALU result
- writeData  out  32  registered forwarded rt value (store data)
- rdOut  out  5  registered destination index

## Operation
- Forwarding, per source (rs → op1 select, rt → op2 select): EX/MEM (this block's own writeBackControlOut[1], rdOut, result) if RegWrite=1, rd≠0, rd==src; else MEM/WB if memWbRegWrite=1, memWbRd≠0, memWbRd==src; else register value. EX/MEM has priority.
- Select encoding: 2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 nominal.
- operand1 = forwarded rs; readData2Forwarded = forwarded rt; operand2 = immediateOperand if aluSrc=1 else readData2Forwarded.
- aluOp: 00 add, 01 subtract, 10 decode funct, 11 pass operand2.
- funct (aluOp=10): 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed, result 1/0), 0x2B sltu, 0x00 sll, 0x02 srl, 0x03 sra (operand2 shifted by shamt). Any other funct → 0.
- Arithmetic is 32-bit modulo 2^32; no overflow flag or trap.
- rdOut = rdIn if regDst=1 else rt.

## Timing
- Forwarding and ALU logic are combinational; outputs update on the falling edge of clk, giving one-stage latency.
- Reset asserted: all outputs go to 0 immediately, independent of clk. While reset is held, EX/MEM forwarding is disabled because the registered RegWrite is 0.
- First falling edge after reset deassertion captures inputs normally.
- Simultaneous EX/MEM and MEM/WB hits on the same register: EX/MEM wins.
- Register 0 is never forwarded.
- No handshake and no stall input; upstream controls bubbles by driving RegWrite and MEM controls to 0.

## Structure
- Shared package: forwarding-select constants (FWD_NONE, FWD_MEMWB, FWD_EXMEM), aluOp encodings, and funct codes.
- Sub-module alu: combinational, with inputs operand1, operand2, aluOp, funct, shamt and output result.
- Sub-module forwarding_unit: combinational, with inputs idExRs, idExRt, exMemRd, exMemRegWrite, memWbRd, memWbRegWrite and outputs operand1Control, operand2Control.
- The top level holds the operand muxes and the pipeline registers.

## Test plan
- Reset pulse mid-run: all outputs go to 0 immediately. After release, add 5+7 with no hazards gives result=12 on the next falling edge.
- Back-to-back dependency: cycle 1 writes rd=3 with result 0x10. Cycle 2 has rs=3 with readData1=0 and funct add, rt value 1. Required result: 0x11 (EX/MEM forwarded).
- MEM/WB forwarding: memWbRegWrite=1, memWbRd=4, memWbData=0xA, rt=4, store with aluSrc=1 and immediate 8. Required: writeData=0xA and result=rs+8.
- Priority and r0: both stages target the same register, so EX/MEM data is used. Both stages target r0, so readData values are used.
- ALU sweep over every listed funct with operands 0xFFFFFFF0 and 0x00000003, plus sra with shamt 4 on 0x80000000 giving 0xF8000000. Unknown funct 0x3F gives 0.
- regDst: regDst=1 gives rdOut=rdIn; regDst=0 gives rdOut=rt. Control buses pass through with one-edge delay.

Source files
------------

// File: rtl/alu_forward_stage_pkg.sv
// Shared definitions for the execute stage: forwarding-select codes,
// ALU operation encodings, R-type funct codes and the forwarding
// priority helper used by the forwarding unit.
package alu_forward_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // Operand source selects produced by the forwarding unit.
  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // aluOp field of calculationControl.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_PASS  = 2'b11;

  // R-type funct codes.
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // Pick the source for one operand. The younger EX/MEM result wins over
  // MEM/WB; register 0 is hard-wired zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] ex_rd,
    input logic             ex_we,
    input logic [REG_W-1:0] wb_rd,
    input logic             wb_we
  );
    if (ex_we && (ex_rd != '0) && (ex_rd == src)) begin
      return FWD_EXMEM;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_NONE;
    end
  endfunction

endpackage

// File: rtl/alu_forward_stage_alu.sv
// Combinational 32-bit ALU for the execute stage.
// Ports:
//   operand1 - first operand (forwarded rs)
//   operand2 - second operand (forwarded rt or immediate); shift source
//   aluOp    - add / sub / funct-decode / pass operand2
//   funct    - R-type function code, used when aluOp selects funct decode
//   shamt    - shift amount for sll/srl/sra
//   result   - ALU result, modulo 2^32, unknown funct yields 0
module alu
  import alu_forward_stage_pkg::*;
(
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [1:0]  aluOp,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);

  logic [31:0] w_funct_result;

  always_comb begin
    w_funct_result = '0;
    case (funct)
      FUNCT_ADD,
      FUNCT_ADDU: w_funct_result = operand1 + operand2;
      FUNCT_SUB,
      FUNCT_SUBU: w_funct_result = operand1 - operand2;
      FUNCT_AND:  w_funct_result = operand1 & operand2;
      FUNCT_OR:   w_funct_result = operand1 | operand2;
      FUNCT_XOR:  w_funct_result = operand1 ^ operand2;
      FUNCT_NOR:  w_funct_result = ~(operand1 | operand2);
      FUNCT_SLT:  w_funct_result = {31'b0, $signed(operand1) < $signed(operand2)};
      FUNCT_SLTU: w_funct_result = {31'b0, operand1 < operand2};
      // Shifts act on operand2 (rt), with the amount taken from shamt.
      FUNCT_SLL:  w_funct_result = operand2 << shamt;
      FUNCT_SRL:  w_funct_result = operand2 >> shamt;
      FUNCT_SRA:  w_funct_result = $unsigned($signed(operand2) >>> shamt);
      default:    w_funct_result = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (aluOp)
      ALUOP_ADD:   result = operand1 + operand2;
      ALUOP_SUB:   result = operand1 - operand2;
      ALUOP_FUNCT: result = w_funct_result;
      ALUOP_PASS:  result = operand2;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/alu_forward_stage_forwarding_unit.sv
// Combinational hazard-forwarding selector for the two ALU sources.
// Ports:
//   idExRs, idExRt   - source register indices of the instruction in EX
//   exMemRd          - destination of the instruction now in EX/MEM
//   exMemRegWrite    - that instruction writes a register
//   memWbRd          - destination of the instruction now in MEM/WB
//   memWbRegWrite    - that instruction writes a register
//   operand1Control  - select for the rs path (FWD_* codes)
//   operand2Control  - select for the rt path (FWD_* codes)
module forwarding_unit
  import alu_forward_stage_pkg::*;
(
  input  logic [4:0] idExRs,
  input  logic [4:0] idExRt,
  input  logic [4:0] exMemRd,
  input  logic       exMemRegWrite,
  input  logic [4:0] memWbRd,
  input  logic       memWbRegWrite,
  output logic [1:0] operand1Control,
  output logic [1:0] operand2Control
);

  always_comb begin
    operand1Control = fwd_sel(idExRs, exMemRd, exMemRegWrite, memWbRd, memWbRegWrite);
    operand2Control = fwd_sel(idExRt, exMemRd, exMemRegWrite, memWbRd, memWbRegWrite);
  end

endmodule

// File: rtl/alu_forward_stage.sv
// Execute stage: forwards operands from EX/MEM and MEM/WB, computes the ALU
// result and registers the EX/MEM pipeline outputs on the falling clock edge.
// There is no handshake: every falling edge captures a new instruction; a
// bubble is an instruction with RegWrite and MEM controls at 0.
// Ports:
//   clk, reset               - clock (falling-edge active), async active-high reset
//   writeBackControlIn[1:0]  - WB controls, bit 1 = RegWrite
//   memAccessControlIn[1:0]  - MEM controls, passed through
//   calculationControl[3:0]  - {regDst, aluOp[1:0], aluSrc}
//   readData1/readData2      - register file values for rs/rt
//   immediateOperand         - sign-extended immediate; [10:6] shamt, [5:0] funct
//   rs, rt, rdIn             - register indices
//   memWbRegWrite/Rd/Data    - MEM/WB write-back bypass
//   writeBackControlOut, memAccessControlOut, result, writeData, rdOut
//                            - registered EX/MEM outputs
module alu_forward_stage
  import alu_forward_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  writeBackControlIn,
  input  logic [1:0]  memAccessControlIn,
  input  logic [3:0]  calculationControl,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2,
  input  logic [31:0] immediateOperand,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rdIn,
  input  logic        memWbRegWrite,
  input  logic [4:0]  memWbRd,
  input  logic [31:0] memWbData,
  output logic [1:0]  writeBackControlOut,
  output logic [1:0]  memAccessControlOut,
  output logic [31:0] result,
  output logic [31:0] writeData,
  output logic [4:0]  rdOut
);

  logic [1:0]  r_wb_ctrl;
  logic [1:0]  r_mem_ctrl;
  logic [31:0] r_result;
  logic [31:0] r_write_data;
  logic [4:0]  r_rd;

  logic        w_reg_dst;
  logic [1:0]  w_alu_op;
  logic        w_alu_src;
  logic [1:0]  w_op1_sel;
  logic [1:0]  w_op2_sel;
  logic [31:0] w_operand1;
  logic [31:0] w_rd2_fwd;
  logic [31:0] w_operand2;
  logic [31:0] w_alu_result;
  logic [4:0]  w_rd_next;

  assign w_reg_dst = calculationControl[3];
  assign w_alu_op  = calculationControl[2:1];
  assign w_alu_src = calculationControl[0];

  // The EX/MEM source for forwarding is this stage's own output register;
  // while reset holds it, r_wb_ctrl[1] is 0 so nothing is forwarded from it.
  forwarding_unit u_fwd (
    .idExRs          (rs),
    .idExRt          (rt),
    .exMemRd         (r_rd),
    .exMemRegWrite   (r_wb_ctrl[1]),
    .memWbRd         (memWbRd),
    .memWbRegWrite   (memWbRegWrite),
    .operand1Control (w_op1_sel),
    .operand2Control (w_op2_sel)
  );

  always_comb begin
    w_operand1 = readData1;
    case (w_op1_sel)
      FWD_EXMEM: w_operand1 = r_result;
      FWD_MEMWB: w_operand1 = memWbData;
      default:   w_operand1 = readData1;
    endcase
  end

  always_comb begin
    w_rd2_fwd = readData2;
    case (w_op2_sel)
      FWD_EXMEM: w_rd2_fwd = r_result;
      FWD_MEMWB: w_rd2_fwd = memWbData;
      default:   w_rd2_fwd = readData2;
    endcase
  end

  // Store data always takes the forwarded rt, even when the immediate
  // feeds the ALU.
  assign w_operand2 = w_alu_src ? immediateOperand : w_rd2_fwd;
  assign w_rd_next  = w_reg_dst ? rdIn : rt;

  alu u_alu (
    .operand1 (w_operand1),
    .operand2 (w_operand2),
    .aluOp    (w_alu_op),
    .funct    (immediateOperand[5:0]),
    .shamt    (immediateOperand[10:6]),
    .result   (w_alu_result)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_wb_ctrl    <= '0;
      r_mem_ctrl   <= '0;
      r_result     <= '0;
      r_write_data <= '0;
      r_rd         <= '0;
    end else begin
      r_wb_ctrl    <= writeBackControlIn;
      r_mem_ctrl   <= memAccessControlIn;
      r_result     <= w_alu_result;
      r_write_data <= w_rd2_fwd;
      r_rd         <= w_rd_next;
    end
  end

  assign writeBackControlOut = r_wb_ctrl;
  assign memAccessControlOut = r_mem_ctrl;
  assign result              = r_result;
  assign writeData           = r_write_data;
  assign rdOut               = r_rd;

endmodule

// File: tb/tb_alu_forward_stage.sv
// Bench for alu_forward_stage: directed vectors with literal expectations,
// plus a reference model compared against the DUT at every rising edge.
module tb_alu_forward_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  wb_in;
  logic [1:0]  mem_in;
  logic [3:0]  calc;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd_in;
  logic        mwb_we;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic [1:0]  wb_out;
  logic [1:0]  mem_out;
  logic [31:0] result;
  logic [31:0] write_data;
  logic [4:0]  rd_out;

  int n_total = 0;
  int n_pass  = 0;

  alu_forward_stage dut (
    .clk                 (clk),
    .reset               (reset),
    .writeBackControlIn  (wb_in),
    .memAccessControlIn  (mem_in),
    .calculationControl  (calc),
    .readData1           (rd1),
    .readData2           (rd2),
    .immediateOperand    (imm),
    .rs                  (rs),
    .rt                  (rt),
    .rdIn                (rd_in),
    .memWbRegWrite       (mwb_we),
    .memWbRd             (mwb_rd),
    .memWbData           (mwb_data),
    .writeBackControlOut (wb_out),
    .memAccessControlOut (mem_out),
    .result              (result),
    .writeData           (write_data),
    .rdOut               (rd_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model EX/MEM state: what the pipeline register must hold.
  logic [1:0]  m_wb;
  logic [1:0]  m_mem;
  logic [31:0] m_res;
  logic [31:0] m_wd;
  logic [4:0]  m_rd;

  function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regv);
    if (src == 5'd0)                        return regv;
    if (m_wb[1] && m_rd == src)             return m_res;
    if (mwb_we && mwb_rd == src)            return mwb_data;
    return regv;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                          input logic [4:0] sh, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return a - b;
    if (op == 2'd3) return b;
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
      6'h2B: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      6'h00: return 32'(longint'(b) * (64'd1 << sh));
      6'h02: return 32'(longint'(b) / (64'd1 << sh));
      6'h03: return 32'(sb >>> sh);
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk or posedge reset) begin
    logic [31:0] a;
    logic [31:0] t;
    if (reset) begin
      m_wb <= '0; m_mem <= '0; m_res <= '0; m_wd <= '0; m_rd <= '0;
    end else begin
      a = ref_fwd(rs, rd1);
      t = ref_fwd(rt, rd2);
      m_res <= ref_alu(calc[2:1], imm[5:0], imm[10:6], a, calc[0] ? imm : t);
      m_wd  <= t;
      m_rd  <= calc[3] ? rd_in : rt;
      m_wb  <= wb_in;
      m_mem <= mem_in;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model compare on every rising edge (outputs settle after the falling edge).
  always @(posedge clk) begin
    chk("model_result", result, m_res);
    chk("model_wdata",  write_data, m_wd);
    chk("model_rd",     {27'b0, rd_out}, {27'b0, m_rd});
    chk("model_wb",     {30'b0, wb_out}, {30'b0, m_wb});
    chk("model_mem",    {30'b0, mem_out}, {30'b0, m_mem});
  end

  // ---------------- driver ----------------
  // Apply one instruction, let the falling edge capture it, return just after.
  task automatic drive(input logic [1:0] wb, input logic [1:0] mem, input logic [3:0] c,
                       input logic [4:0] s, input logic [31:0] v1,
                       input logic [4:0] t, input logic [31:0] v2,
                       input logic [31:0] im, input logic [4:0] d,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wdat);
    wb_in = wb; mem_in = mem; calc = c;
    rs = s; rd1 = v1; rt = t; rd2 = v2; imm = im; rd_in = d;
    mwb_we = we; mwb_rd = wrd; mwb_data = wdat;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rfun(input logic [4:0] sh, input logic [5:0] f);
    return {21'b0, sh, f};
  endfunction

  // calculationControl = {regDst, aluOp, aluSrc}
  localparam logic [3:0] C_ADD_R  = 4'b1_00_0;
  localparam logic [3:0] C_FUNCT  = 4'b1_10_0;
  localparam logic [3:0] C_PASSI  = 4'b1_11_1;
  localparam logic [3:0] C_STORE  = 4'b0_00_1;
  localparam logic [3:0] C_SUB_R  = 4'b1_01_0;

  typedef struct {
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t sweep[17];

  initial begin
    reset = 1'b1;
    drive(2'b00, 2'b00, 4'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_rd", {27'b0, rd_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Add 5+7, no hazards.
    drive(2'b10, 2'b00, C_ADD_R, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    chk("add_5_7", result, 32'd12);
    chk("add_rd", {27'b0, rd_out}, 32'd5);
    chk("add_wb", {30'b0, wb_out}, 32'd2);

    // Back-to-back: write r3 = 0x10, then consume r3 through EX/MEM.
    drive(2'b10, 2'b00, C_PASSI, 5'd0, 32'd0, 5'd0, 32'd0, 32'h10, 5'd3, 1'b0, 5'd0, 32'd0);
    chk("write_r3", result, 32'h10);
    drive(2'b10, 2'b00, C_FUNCT, 5'd3, 32'd0, 5'd6, 32'd1, rfun(5'd0, 6'h20), 5'd7, 1'b0, 5'd0, 32'd0);
    chk("exmem_fwd", result, 32'h11);

    // MEM/WB forwarding into store data, immediate operand.
    drive(2'b00, 2'b01, C_STORE, 5'd8, 32'h100, 5'd4, 32'h99, 32'd8, 5'd0, 1'b1, 5'd4, 32'hA);
    chk("memwb_wdata", write_data, 32'hA);
    chk("memwb_result", result, 32'h108);
    chk("regdst0_rd", {27'b0, rd_out}, 32'd4);
    chk("mem_pass", {30'b0, mem_out}, 32'd1);

    // Priority: EX/MEM r9=0x55 and MEM/WB r9=0x77 both hit; EX/MEM wins.
    drive(2'b10, 2'b00, C_PASSI, 5'd0, 32'd0, 5'd0, 32'd0, 32'h55, 5'd9, 1'b0, 5'd0, 32'd0);
    drive(2'b10, 2'b11, C_ADD_R, 5'd9, 32'd1, 5'd9, 32'd2, 32'd0, 5'd0, 1'b1, 5'd9, 32'h77);
    chk("prio_result", result, 32'hAA);
    chk("prio_wdata", write_data, 32'h55);
    chk("ctrl_mem11", {30'b0, mem_out}, 32'd3);
    // r0: both stages name r0 with RegWrite set; register values are used.
    drive(2'b01, 2'b00, C_ADD_R, 5'd0, 32'd3, 5'd0, 32'd4, 32'd0, 5'd1, 1'b1, 5'd0, 32'h77);
    chk("r0_result", result, 32'd7);
    chk("r0_wdata", write_data, 32'd4);
    chk("ctrl_wb01", {30'b0, wb_out}, 32'd1);

    // MEM/WB forwarding on rs alone.
    drive(2'b00, 2'b00, C_SUB_R, 5'd12, 32'd0, 5'd13, 32'd3, 32'd0, 5'd1, 1'b1, 5'd12, 32'd10);
    chk("memwb_rs_sub", result, 32'd7);

    // ALU sweep: a = 0xFFFFFFF0, b = 3 (shifts on b with shamt 2).
    sweep[0]  = '{6'h20, 5'd0, 32'd3, 32'hFFFFFFF3};
    sweep[1]  = '{6'h21, 5'd0, 32'd3, 32'hFFFFFFF3};
    sweep[2]  = '{6'h22, 5'd0, 32'd3, 32'hFFFFFFED};
    sweep[3]  = '{6'h23, 5'd0, 32'd3, 32'hFFFFFFED};
    sweep[4]  = '{6'h24, 5'd0, 32'd3, 32'h00000000};
    sweep[5]  = '{6'h25, 5'd0, 32'd3, 32'hFFFFFFF3};
    sweep[6]  = '{6'h26, 5'd0, 32'd3, 32'hFFFFFFF3};
    sweep[7]  = '{6'h27, 5'd0, 32'd3, 32'h0000000C};
    sweep[8]  = '{6'h2A, 5'd0, 32'd3, 32'h00000001};
    sweep[9]  = '{6'h2B, 5'd0, 32'd3, 32'h00000000};
    sweep[10] = '{6'h00, 5'd2, 32'd3, 32'h0000000C};
    sweep[11] = '{6'h02, 5'd2, 32'd3, 32'h00000000};
    sweep[12] = '{6'h03, 5'd2, 32'd3, 32'h00000000};
    sweep[13] = '{6'h3F, 5'd0, 32'd3, 32'h00000000};
    sweep[14] = '{6'h03, 5'd4, 32'h80000000, 32'hF8000000};
    sweep[15] = '{6'h02, 5'd4, 32'h80000000, 32'h08000000};
    sweep[16] = '{6'h00, 5'd4, 32'h80000001, 32'h00000010};
    for (int i = 0; i < 17; i++) begin
      drive(2'b00, 2'b00, C_FUNCT, 5'd10, 32'hFFFFFFF0, 5'd11, sweep[i].b,
            rfun(sweep[i].sh, sweep[i].f), 5'd1, 1'b0, 5'd0, 32'd0);
      chk($sformatf("sweep_%0d_f%02h", i, sweep[i].f), result, sweep[i].exp);
    end

    // Reset mid-run: outputs clear without a clock edge.
    drive(2'b10, 2'b11, C_ADD_R, 5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 5'd7, 1'b0, 5'd0, 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_result", result, 32'd0);
    chk("async_wb", {30'b0, wb_out}, 32'd0);
    chk("async_mem", {30'b0, mem_out}, 32'd0);
    chk("async_rd", {27'b0, rd_out}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    // rs=7 would hit the pre-reset EX/MEM rd=7 if reset had not cleared it.
    drive(2'b00, 2'b00, C_ADD_R, 5'd7, 32'd5, 5'd2, 32'd7, 32'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    chk("post_reset_add", result, 32'd12);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
